// File: rtl/interleave_pkg.sv
// Shared constants and FSM encoding for the interleaver address path.
// The downstream rotation stage imports the same index width.
package interleave_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int FRAME_LEN  = 2 ** ADDR_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/idx_counter.sv
// Frame index counter shared by the FILL and DRAIN phases.
// A synchronous clear wins over the enable; tc flags the last index of the frame.
module idx_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = &count;

endmodule

// File: rtl/interleave_addr_gen.sv
// Frame sequencer for the interleaver buffer: linear FILL writes, then linear
// DRAIN read indices for the rotation stage, with handshakes and abort.
module interleave_addr_gen
    import interleave_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int CONTINUOUS = 0,
    parameter int FCNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] adress,
    output logic              rd_en,
    output logic              frame_done,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt
);

    state_e            state;
    logic [ADDR_W-1:0] idx;
    logic              idx_tc;
    logic              idx_clr;
    logic              idx_en;
    logic              last_xfer;

    idx_counter #(
        .W (ADDR_W)
    ) u_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (idx_clr),
        .en    (idx_en),
        .count (idx),
        .tc    (idx_tc)
    );

    // abort masks the handshake in the same cycle, so it can never race a transfer
    always_comb begin
        in_ready  = (state == FILL) && !abort;
        out_valid = (state == DRAIN) && !abort;
        wr_en     = in_valid && in_ready;
        rd_en     = out_valid && out_ready;
        wr_addr   = (state == FILL) ? idx : '0;
        adress    = (state == DRAIN) ? idx : '0;
        busy      = (state != IDLE);
        last_xfer = rd_en && idx_tc;
        idx_en    = wr_en || rd_en;
        idx_clr   = (state == IDLE) || abort || ((wr_en || rd_en) && idx_tc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= last_xfer;
            if (last_xfer) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (wr_en && idx_tc) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (last_xfer) begin
                        state <= (CONTINUOUS != 0) ? FILL : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
